mac_array_seq: RTL and testbench
================================

# mac_array_seq

Job-level sequencer for the 8x8 MAC array. On `start`, it latches the job's mode: weight-stationary (WS) or output-stationary (OS), and 2-bit activation mode. It then issues the array's instruction stream on `inst_w` as kernel-load, execute, flush and drain phases. It pops the L0 activation/weight FIFO that feeds `in_w`, stalls on FIFO underflow, counts valid output beats and pulses `done` when the array is quiet.

## Interface
- `row`, default 8: array rows; sets the instruction skew depth.
- `col`, default 8: array columns; sets the WS kernel-load beat count.
- `inst_bw`, default 3: instruction width. bit0 = kernel load, bit1 = execute, bit2 = flush psum.
- `len_bw`, default 8: width of the execute beat count.
- `cnt_bw`, default 12: width of the output beat counter.

Ports (reset: synchronous, active-high, `reset`; clock: `clk`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `mode_os` in 1: job mode, latched at start. 1 = OS, 0 = WS.
- `mode_2b` in 1: 2-bit activation mode, latched at start.
- `exec_len` in `len_bw`: number of execute beats, latched at start.
- `l0_empty` in 1: L0 FIFO empty.
- `valid` in `col`: valid vector from the array.
- `l0_rd` out 1: L0 pop. Combinationally equals beat-issue qualification.
- `inst_w` out `inst_bw`: registered instruction to array row 0.
- `is_os` out 1: latched mode to the array.
- `act_2b_mode` out 1: latched mode to the array.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `out_cnt` out `cnt_bw`: cycles with any `valid` bit set during the current job.

## Operation
- States: IDLE, KLOAD, KGAP, EXEC, FLUSH, DRAIN.
- IDLE:
  - `inst_w` = 0 and `busy` = 0.
  - On `start`: latch `mode_os`, `mode_2b`, `exec_len`; clear `out_cnt`.
  - Next state is KLOAD if WS, else EXEC.
- KLOAD (WS only): issue `col` kernel-load beats.
  - A beat issues in a cycle where `!l0_empty`: `l0_rd` = 1 and next `inst_w` = 3'b001.
  - When `l0_empty` = 1: `l0_rd` = 0 and next `inst_w` = 3'b000 (bubble). The beat counter does not advance.
  - Goes to KGAP after the `col`-th beat.
- KGAP: `inst_w` = 0 for exactly `row` cycles, so the load instruction clears every row. Then go to EXEC.
- EXEC: issue `exec_len` execute beats with the same stall rule; the beat instruction is 3'b010.
  - If `exec_len` = 0, the state lasts 0 cycles: skip directly to FLUSH (OS) or DRAIN (WS).
  - After the last beat, go to FLUSH if OS, else DRAIN.
- FLUSH (OS only):
  - `inst_w` = 3'b100 for exactly 1 cycle. The skew carries it down one row per cycle, so rows emit their psums in order.
  - No L0 pop. Then go to DRAIN.
- DRAIN:
  - `inst_w` = 0 for `row+col` cycles.
  - In the last DRAIN cycle `done` = 1 for one cycle; the next state is IDLE.
- `out_cnt` increments in every cycle where `busy` and `|valid`.
  - It saturates at all-ones.
  - It holds its value in IDLE until the next `start`.
- `start` while `busy` is ignored; no queueing.
- Changes on `mode_os`, `mode_2b` or `exec_len` after start have no effect until the next job.

## Timing
- Reset, including mid-job: state → IDLE next edge. Reset values:
  - `inst_w` = 0
  - `l0_rd` = 0
  - `busy` = 0
  - `done` = 0
  - `is_os` = 0
  - `act_2b_mode` = 0
  - `out_cnt` = 0
- Nothing is popped in the reset cycle.
- `start` sampled at edge t:
  - `busy` = 1 from t+1.
  - The first `l0_rd` can assert at cycle t+1.
  - The matching `inst_w` beat appears at t+2; beats are registered 1 cycle after the pop.
- `busy` falls in the cycle after the `done` pulse.
- IDLE → IDLE: a new `start` is accepted the cycle after `done`.
- Job length with no stalls:
  - WS: 1 + `col` + `row` + `exec_len` + (`row+col`) cycles of `busy`.
  - OS: 1 + `exec_len` + 1 + (`row+col`) cycles of `busy`.
- Each L0 empty cycle in KLOAD/EXEC extends the job by exactly 1 cycle.
- Exactly one `inst_w` beat is issued per `l0_rd` pulse; `inst_w` is never nonzero without a preceding pop, except FLUSH.

## Test plan
- WS, `exec_len` = 16, L0 never empty:
  - 8 beats of 001, then 8 zero cycles, then 16 beats of 010, then 16 zero cycles.
  - `done` at busy cycle 49.
  - `l0_rd` count = 24.
  - `is_os` = 0 throughout.
- OS, `exec_len` = 10:
  - no 001 beats, then 10 × 010, then one 100, then 16 zero cycles.
  - `done` 28 cycles after start (busy cycles 1..28).
  - `l0_rd` count = 10.
- WS, `exec_len` = 4, `l0_empty` high for 3 cycles mid-EXEC:
  - 3 zero bubbles are inserted, no pop while empty.
  - `done` delayed by exactly 3 cycles versus the unstalled run.
- OS, `exec_len` = 0: state goes EXEC → FLUSH directly; one 100 beat, zero pops, `done` after 18 busy cycles.
- Reset asserted during EXEC beat 5 of 16: next cycle all outputs are 0 and the state is IDLE. A following `start` runs a full fresh job with `out_cnt` starting from 0.
- `start` held high throughout a job with `valid` = 0x01 for 9 cycles:
  - exactly one job runs, `out_cnt` = 9.
  - a second job is accepted the cycle after `done`, and `out_cnt` is cleared at that start.

Source files
------------

// File: rtl/mac_array_seq_if.sv
// Job/status bundle between the MAC array sequencer and its controller.
// The slave side is the sequencer; the master side drives jobs and L0 status.
interface mac_array_seq_if #(
  parameter int col     = 8,
  parameter int inst_bw = 3,
  parameter int len_bw  = 8,
  parameter int cnt_bw  = 12
);
  logic               start;
  logic               mode_os;
  logic               mode_2b;
  logic [len_bw-1:0]  exec_len;
  logic               l0_empty;
  logic [col-1:0]     valid;
  logic               l0_rd;
  logic [inst_bw-1:0] inst_w;
  logic               is_os;
  logic               act_2b_mode;
  logic               busy;
  logic               done;
  logic [cnt_bw-1:0]  out_cnt;

  modport master (
    output start, mode_os, mode_2b, exec_len,
    output l0_empty, valid,
    input  l0_rd, inst_w, is_os, act_2b_mode,
    input  busy, done, out_cnt
  );

  modport slave (
    input  start, mode_os, mode_2b, exec_len,
    input  l0_empty, valid,
    output l0_rd, inst_w, is_os, act_2b_mode,
    output busy, done, out_cnt
  );
endinterface

// File: rtl/mac_array_seq.sv
// Job-level sequencer for the MAC array: kernel load, execute,
// flush and drain phases, L0 pops and output beat counting.
module mac_array_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int inst_bw = 3,
  parameter int len_bw  = 8,
  parameter int cnt_bw  = 12
) (
  input logic            clk,
  input logic            reset,
  mac_array_seq_if.slave bus
);
  // Drain holds one extra state cycle so the registered inst_w
  // shows row+col zero cycles after the final beat.
  localparam int DL = row + col + 1;
  localparam int PW = $clog2(DL + 1);
  localparam int CW = (PW > len_bw) ? PW : len_bw;

  localparam logic [CW-1:0] K_LAST = CW'(col - 1);
  localparam logic [CW-1:0] G_LAST = CW'(row - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DL - 1);

  localparam logic [inst_bw-1:0] I_LOAD  = inst_bw'(1);
  localparam logic [inst_bw-1:0] I_EXEC  = inst_bw'(2);
  localparam logic [inst_bw-1:0] I_FLUSH = inst_bw'(4);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KLOAD = 3'd1;
  localparam logic [2:0] S_KGAP  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [len_bw-1:0]  len_q, len_d;
  logic               os_q, os_d;
  logic               m2b_q, m2b_d;
  logic [inst_bw-1:0] inst_q, inst_d;
  logic [cnt_bw-1:0]  out_q, out_d;

  logic busy;
  logic beat;
  logic done_c;
  logic exec_last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    os_d      = os_q;
    m2b_d     = m2b_q;
    inst_d    = '0;
    out_d     = out_q;
    done_c    = 1'b0;
    busy      = (state_q != S_IDLE);
    beat      = ((state_q == S_KLOAD) ||
                 (state_q == S_EXEC)) &&
                !bus.l0_empty;
    exec_last = ((cnt_q + CW'(1)) == CW'(len_q));

    if (busy && |bus.valid && out_q != '1)
      out_d = out_q + cnt_bw'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          os_d  = bus.mode_os;
          m2b_d = bus.mode_2b;
          len_d = bus.exec_len;
          out_d = '0;
          cnt_d = '0;
          if (!bus.mode_os)
            state_d = S_KLOAD;
          else if (bus.exec_len == '0)
            state_d = S_FLUSH;
          else
            state_d = S_EXEC;
        end
      end
      S_KLOAD: begin
        if (beat) begin
          inst_d = I_LOAD;
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = S_KGAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_KGAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? S_DRAIN : S_EXEC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (beat) begin
          inst_d = I_EXEC;
          if (exec_last) begin
            cnt_d   = '0;
            state_d = os_q ? S_FLUSH : S_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        inst_d  = I_FLUSH;
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == D_LAST) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      os_q    <= 1'b0;
      m2b_q   <= 1'b0;
      inst_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      os_q    <= os_d;
      m2b_q   <= m2b_d;
      inst_q  <= inst_d;
      out_q   <= out_d;
    end
  end

  assign bus.l0_rd       = beat & ~reset;
  assign bus.inst_w      = inst_q;
  assign bus.is_os       = os_q;
  assign bus.act_2b_mode = m2b_q;
  assign bus.busy        = busy;
  assign bus.done        = done_c;
  assign bus.out_cnt     = out_q;
endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: jobs are modelled as phase
// lengths and beat lists, a negedge monitor checks what the DUT emits.
module tb_mac_array_seq;
  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int MAXC = 512;

  typedef struct {
    int dcyc;
    int ocnt;
    int pops;
    bit os;
    bit m2b;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_array_seq_if b ();
  mac_array_seq u_dut (.clk(clk), .reset(reset), .bus(b));

  job_t jq[$];
  int   iq[$];
  job_t mj;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   bc = 0;
  int   pops = 0;
  bit   prev_done = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      bc = 0;
      pops = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", b.busy, 0);
      if (b.busy) begin
        bc++;
        if (b.l0_rd) begin
          pops++;
          chk("pop_while_empty", b.l0_empty, 0);
        end
      end else begin
        chk("idle_rd", b.l0_rd, 0);
        chk("idle_inst", b.inst_w, 0);
        chk("idle_done", b.done, 0);
      end
      if (b.inst_w != 0) begin
        if (iq.size() == 0) chk("inst_without_pop", iq.size(), 1);
        else chk("inst_beat", b.inst_w, iq.pop_front());
      end
      if (b.done) begin
        if (jq.size() == 0) begin
          chk("done_without_job", jq.size(), 1);
        end else begin
          mj = jq.pop_front();
          chk("done_cycle", bc, mj.dcyc);
          chk("out_cnt", b.out_cnt, mj.ocnt);
          chk("pop_count", pops, mj.pops);
          chk("is_os", b.is_os, mj.os);
          chk("act_2b_mode", b.act_2b_mode, mj.m2b);
          chk("beats_left", iq.size(), 0);
        end
        bc = 0;
        pops = 0;
      end
      prev_done = b.done;
    end
  end

  // smode: 0 never empty, 1 random empties, 2 burst of 3 in EXEC
  // vmode: 0 random valid in cycles 1..16, 1 valid=1 in cycles 1..9
  task automatic run_job(input bit os, input bit m2b, input int len,
                         input int smode, input int vmode,
                         input bit hold);
    bit emp[MAXC];
    int vld[MAXC];
    int k, n, d, oc;
    for (int i = 0; i < MAXC; i++) begin
      emp[i] = (smode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      vld[i] = 0;
    end
    if (smode == 2) begin
      emp[18] = 1'b1;
      emp[19] = 1'b1;
      emp[20] = 1'b1;
    end
    for (int i = 1; i <= 16; i++) begin
      if (vmode == 1) vld[i] = (i <= 9) ? 1 : 0;
      else if ($urandom_range(0, 1) == 1) vld[i] = $urandom_range(0, 255);
    end
    k = 0;
    if (!os) begin
      n = 0;
      while (n < COL && k < MAXC - 1) begin
        k++;
        if (!emp[k]) n++;
      end
      k += ROW;
    end
    n = 0;
    while (n < len && k < MAXC - 1) begin
      k++;
      if (!emp[k]) n++;
    end
    if (os) k += 1;
    k += ROW + COL + 1;
    d = k;
    oc = 0;
    for (int i = 1; i < d && i < MAXC; i++)
      if (vld[i] != 0) oc++;
    if (!os) repeat (COL) iq.push_back(1);
    repeat (len) iq.push_back(2);
    if (os) iq.push_back(4);
    jq.push_back('{d, oc, (os ? 0 : COL) + len, os, m2b});

    b.start    = 1'b1;
    b.mode_os  = os;
    b.mode_2b  = m2b;
    b.exec_len = 8'(len);
    b.l0_empty = 1'($urandom_range(0, 1));
    b.valid    = '0;
    for (int i = 1; i <= d; i++) begin
      @(posedge clk);
      #1;
      b.start    = hold;
      b.mode_os  = 1'($urandom_range(0, 1));
      b.mode_2b  = 1'($urandom_range(0, 1));
      b.exec_len = 8'($urandom_range(0, 255));
      b.l0_empty = (i < MAXC) ? emp[i] : 1'b0;
      b.valid    = (i < MAXC) ? 8'(vld[i]) : 8'h00;
    end
    @(posedge clk);
    #1;
    b.valid = '0;
    if (!hold) begin
      b.start = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        b.valid    = 8'($urandom_range(1, 255));
        b.l0_empty = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("out_cnt_hold", b.out_cnt, oc);
        @(posedge clk);
        #1;
      end
      b.valid = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    b.start    = 1'b0;
    b.mode_os  = 1'b0;
    b.mode_2b  = 1'b0;
    b.exec_len = '0;
    b.l0_empty = 1'b0;
    b.valid    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_w", b.inst_w, 0);
    chk("rst_l0_rd", b.l0_rd, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_is_os", b.is_os, 0);
    chk("rst_act_2b", b.act_2b_mode, 0);
    chk("rst_out_cnt", b.out_cnt, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_job(1'b0, 1'b0, 16, 0, 0, 1'b0);
    run_job(1'b1, 1'b1, 10, 0, 0, 1'b0);
    run_job(1'b0, 1'b1, 4, 2, 0, 1'b0);
    run_job(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // reset in the middle of an OS job, during execute beat 5
    mon_en     = 1'b0;
    b.start    = 1'b1;
    b.mode_os  = 1'b1;
    b.mode_2b  = 1'b1;
    b.exec_len = 8'd16;
    b.l0_empty = 1'b0;
    b.valid    = 8'h01;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_out_cnt", b.out_cnt, 4);
    chk("rst_cycle_l0_rd", b.l0_rd, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    b.valid = '0;
    @(negedge clk);
    chk("mid_rst_inst_w", b.inst_w, 0);
    chk("mid_rst_l0_rd", b.l0_rd, 0);
    chk("mid_rst_busy", b.busy, 0);
    chk("mid_rst_done", b.done, 0);
    chk("mid_rst_is_os", b.is_os, 0);
    chk("mid_rst_act_2b", b.act_2b_mode, 0);
    chk("mid_rst_out_cnt", b.out_cnt, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    run_job(1'b0, 1'b0, 16, 0, 0, 1'b0);

    run_job(1'b1, 1'b0, 12, 0, 1, 1'b1);
    run_job(1'b0, 1'b1, 6, 0, 0, 1'b0);

    for (int j = 0; j < 20; j++)
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 20), 1, 0,
              (j < 19) ? 1'($urandom_range(0, 1)) : 1'b0);

    @(negedge clk);
    chk("jobs_pending", jq.size(), 0);
    chk("beats_pending", iq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
